audio_i2s_tx: RTL

Parametrised I2S transmitter for the Pocket audio path. Replaces the silence generator.
- Derives MCLK from the 74.25 MHz bridge clock with a fractional accumulator.
- Derives SCLK and LRCK from MCLK.
- Shifts real stereo samples taken from a valid/ready stream.
- Outputs drive audio_mclk, audio_dac and audio_lrck directly.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/audio_mclk_gen.sv | 56 +++++
 rtl/audio_i2s_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the I2S transmitter.
//   SLOT_BITS / FRAME_BITS : SCLK periods per channel slot / per stereo frame.
//   DEFAULT_ACCUM_INC/MOD  : fractional MCLK divider defaults (74.25 MHz -> 12.288 MHz).
//   stereo_sample_t        : left/right pair.
package audio_pkg;

  localparam int unsigned SLOT_BITS         = 32;
  localparam int unsigned FRAME_BITS        = 64;
  localparam int unsigned BIT_CNT_W         = $clog2(FRAME_BITS);
  localparam int unsigned POS_W             = $clog2(SLOT_BITS);
  localparam int unsigned DEFAULT_ACCUM_INC = 245760;
  localparam int unsigned DEFAULT_ACCUM_MOD = 742500;
  localparam int unsigned SAMPLE_WIDTH_MAX  = 24;

  // A package type cannot follow a module parameter, so the pair is sized for
  // the widest legal sample; narrower samples sit right-aligned, upper bits zero.
  typedef struct packed {
    logic [SAMPLE_WIDTH_MAX-1:0] left;
    logic [SAMPLE_WIDTH_MAX-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/audio_mclk_gen.sv
// audio_mclk_gen: fractional-accumulator MCLK generator plus MCLK/4 bit clock.
// Ports:
//   i_clk        - 74.25 MHz bridge clock
//   i_rst_n      - synchronous active-low reset
//   o_mclk       - master clock (toggles on every accumulator wrap)
//   o_sclk       - bit clock, MCLK/4
//   o_sclk_fall  - one-cycle strobe in the cycle the divider wraps 3->0
module audio_mclk_gen
  import audio_pkg::*;
#(
  parameter int unsigned ACCUM_INC = DEFAULT_ACCUM_INC,
  parameter int unsigned ACCUM_MOD = DEFAULT_ACCUM_MOD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_mclk,
  output logic o_sclk,
  output logic o_sclk_fall
);

  localparam int unsigned AW = $clog2(ACCUM_MOD + ACCUM_INC);
  localparam logic [AW-1:0] INC = AW'(ACCUM_INC);
  localparam logic [AW-1:0] MOD = AW'(ACCUM_MOD);

  logic [AW-1:0] r_accum;
  logic          r_mclk;
  logic [1:0]    r_div;

  logic [AW-1:0] w_sum;
  logic          w_wrap;
  logic          w_rise;

  always_comb begin
    w_sum  = r_accum + INC;
    w_wrap = (w_sum >= MOD);
    w_rise = w_wrap && !r_mclk;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_accum <= '0;
      r_mclk  <= 1'b0;
      r_div   <= '0;
    end else begin
      r_accum <= w_wrap ? (w_sum - MOD) : w_sum;
      if (w_wrap) r_mclk <= ~r_mclk;
      if (w_rise) r_div <= r_div + 2'd1;
    end
  end

  assign o_mclk      = r_mclk;
  assign o_sclk      = r_div[1];
  // Combinational so the frame logic updates in the same edge as SCLK falls.
  assign o_sclk_fall = w_rise && (r_div == 2'b11);

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter fed by a one-entry valid/ready sample buffer.
// Build option: define AUDIO_I2S_UNDERRUN_HOLD_EN to repeat the last pair on
// underrun; otherwise an underrun frame is silence.
// Ports:
//   clk_74a                  - 74.25 MHz clock
//   reset_n                  - synchronous active-low reset
//   sample_valid/ready       - stereo pair handshake (ready = buffer empty)
//   sample_left/right        - signed samples, SAMPLE_WIDTH bits
//   audio_mclk/sclk/lrck/dac - I2S pins (lrck 0 = left, MSB first, 1-bit delay)
//   frame_start              - pulse when a frame is loaded
//   underrun                 - saturating count of frames with no buffered pair
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned ACCUM_INC    = DEFAULT_ACCUM_INC,
  parameter int unsigned ACCUM_MOD    = DEFAULT_ACCUM_MOD,
  parameter int unsigned UNDERRUN_W   = 16
) (
  input  logic                    clk_74a,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    audio_mclk,
  output logic                    audio_sclk,
  output logic                    audio_lrck,
  output logic                    audio_dac,
  output logic                    frame_start,
  output logic [UNDERRUN_W-1:0]   underrun
);

  logic w_sclk_fall;

  audio_mclk_gen #(
    .ACCUM_INC(ACCUM_INC),
    .ACCUM_MOD(ACCUM_MOD)
  ) u_mclk_gen (
    .i_clk      (clk_74a),
    .i_rst_n    (reset_n),
    .o_mclk     (audio_mclk),
    .o_sclk     (audio_sclk),
    .o_sclk_fall(w_sclk_fall)
  );

  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_lrck;
  logic                  r_dac;
  logic                  r_full;
  logic                  r_frame_start;
  logic [UNDERRUN_W-1:0] r_underrun;
  stereo_sample_t        r_buf;
  stereo_sample_t        r_shift;

  logic [BIT_CNT_W-1:0]        w_bit_next;
  logic [POS_W-1:0]            w_pos;
  logic [POS_W-1:0]            w_idx;
  logic [SAMPLE_WIDTH_MAX-1:0] w_word;
  logic                        w_bit;
  logic                        w_load;
  logic                        w_accept;

  always_comb begin
    w_bit_next = r_bit_cnt + BIT_CNT_W'(1);
    w_pos      = w_bit_next[POS_W-1:0];
    w_idx      = POS_W'(SAMPLE_WIDTH) - w_pos;
    w_word     = w_bit_next[BIT_CNT_W-1] ? r_shift.right : r_shift.left;
    w_load     = w_sclk_fall && (w_bit_next == '0);
    w_accept   = sample_valid && !r_full;
    // Position 0 is the I2S delay bit; positions past the sample pad with 0.
    // The load cycle is always position 0, so the stale shift content is never used.
    w_bit      = 1'b0;
    if ((w_pos != '0) && (32'(w_pos) <= SAMPLE_WIDTH)) w_bit = w_word[w_idx];
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      r_bit_cnt     <= '1;
      r_lrck        <= 1'b0;
      r_dac         <= 1'b0;
      r_full        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= '0;
      r_buf         <= '0;
      r_shift       <= '0;
    end else begin
      r_frame_start <= w_load;
      if (w_sclk_fall) begin
        r_bit_cnt <= w_bit_next;
        r_lrck    <= w_bit_next[BIT_CNT_W-1];
        r_dac     <= w_bit;
      end
      if (w_load) begin
        if (r_full) begin
          r_shift <= r_buf;
        end else begin
          if (r_underrun != '1) r_underrun <= r_underrun + UNDERRUN_W'(1);
`ifndef AUDIO_I2S_UNDERRUN_HOLD_EN
          r_shift <= '0;
`endif
        end
      end
      // A load only clears a full buffer, and ready is low then, so an accept
      // and a clear never compete.
      if (w_accept) begin
        r_full      <= 1'b1;
        r_buf.left  <= SAMPLE_WIDTH_MAX'(sample_left);
        r_buf.right <= SAMPLE_WIDTH_MAX'(sample_right);
      end else if (w_load) begin
        r_full <= 1'b0;
      end
    end
  end

  assign sample_ready = !r_full;
  assign audio_lrck   = r_lrck;
  assign audio_dac    = r_dac;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

endmodule
